hybrid_cache_memresp: RTL and testbench

Memory-side responder for the `hybrid_cache_line` memory port: accepts the line's `mem_rdreq`/`mem_wrreq` traffic, queues it in a small request FIFO, services it in order against an internal word-addressed RAM with configurable read latency, and returns read data with a one-cycle `mem_out_valid` pulse. It sits between the cache line (or cache controller) and the backing store. It drives the back-pressure signal that feeds `cache_line_pause`.

---
 rtl/hybrid_cache_pkg.sv | 18 +
 rtl/hybrid_cache_reqfifo.sv | 51 +++++
 rtl/hybrid_cache_memresp.sv | 155 +++++++++++++++
 tb/tb_hybrid_cache_memresp.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_cache_pkg.sv
// Shared types for the hybrid cache memory responder.
// Request entries are packed {is_write, index, data}, MSB first.
package hybrid_cache_pkg;

   localparam int WORD_OFS = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ_WAIT,
      ST_RESP
   } state_t;

   function automatic int entry_width(input int idx_w, input int data_w);
      return 1 + idx_w + data_w;
   endfunction

endpackage

// File: rtl/hybrid_cache_reqfifo.sv
// Synchronous request FIFO; a push into a full FIFO is taken
// only when a pop happens on the same edge.
module hybrid_cache_reqfifo #(
   parameter int W = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      cnt <= cnt + 1'b1;
         else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/hybrid_cache_memresp.sv
// Memory-side responder: queues cache-line requests and services
// them in order against a word RAM with fixed read latency.
module hybrid_cache_memresp
   import hybrid_cache_pkg::*;
#(
   parameter int ADDRBITS     = 32,
   parameter int DATABITS     = 32,
   parameter int MEMADDRBITS  = 10,
   parameter int FIFODEPTH    = 4,
   parameter int READLAT      = 2,
   parameter int PAUSE_MARGIN = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDRBITS-1:0] mem_addr,
   input  logic [DATABITS-1:0] mem_in,
   input  logic                mem_wrreq,
   input  logic                mem_rdreq,
   output logic [DATABITS-1:0] mem_out,
   output logic                mem_out_valid,
   output logic                mem_pause,
   output logic                mem_busy,
   output logic                err_overflow,
   output logic                err_proto
);

   localparam int EW = entry_width(MEMADDRBITS, DATABITS);
   localparam int CW = $clog2(FIFODEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFODEPTH);
   localparam logic [2:0] LAT_LOAD = 3'(READLAT - 1);

   logic                   req;
   logic [MEMADDRBITS-1:0] req_idx;
   logic                   unused_addr;
   logic [EW-1:0]          f_wdata;
   logic [EW-1:0]          f_rdata;
   logic                   f_pop;
   logic                   f_full;
   logic                   f_empty;
   logic [CW-1:0]          f_count;
   logic                   head_wr;
   logic [MEMADDRBITS-1:0] head_idx;
   logic [DATABITS-1:0]    head_data;

   state_t                 state;
   state_t                 state_nx;
   logic [2:0]             cnt;
   logic [2:0]             cnt_nx;
   logic                   ram_we;
   logic                   rd_en;
   logic                   resp;
   logic [MEMADDRBITS-1:0] cur_idx;
   logic [DATABITS-1:0]    cur_data;
   logic [DATABITS-1:0]    rd_data;
   logic [DATABITS-1:0]    ram [2**MEMADDRBITS];

   // Low byte-offset bits and high bits alias onto the same word.
   assign req     = mem_wrreq | mem_rdreq;
   assign req_idx = mem_addr[MEMADDRBITS+WORD_OFS-1:WORD_OFS];
   assign unused_addr = ^{mem_addr[ADDRBITS-1:MEMADDRBITS+WORD_OFS],
                          mem_addr[WORD_OFS-1:0]};
   assign f_wdata = {mem_wrreq, req_idx, mem_in};

   assign head_wr   = f_rdata[EW-1];
   assign head_idx  = f_rdata[EW-2 -: MEMADDRBITS];
   assign head_data = f_rdata[DATABITS-1:0];

   hybrid_cache_reqfifo #(
      .W     (EW),
      .DEPTH (FIFODEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req),
      .pop   (f_pop),
      .wdata (f_wdata),
      .rdata (f_rdata),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   assign mem_pause = (DEPTH_C - f_count) < CW'(PAUSE_MARGIN);
   assign mem_busy  = !f_empty || (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         err_overflow <= 1'b0;
         err_proto    <= 1'b0;
      end else begin
         if (mem_wrreq && mem_rdreq) err_proto <= 1'b1;
         if (req && f_full && !f_pop) err_overflow <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      f_pop    = 1'b0;
      ram_we   = 1'b0;
      rd_en    = 1'b0;
      resp     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!f_empty) begin
               f_pop = 1'b1;
               if (head_wr) begin
                  state_nx = ST_WRITE;
               end else begin
                  state_nx = ST_READ_WAIT;
                  cnt_nx   = LAT_LOAD;
               end
            end
         end
         ST_WRITE: begin
            ram_we   = 1'b1;
            state_nx = ST_IDLE;
         end
         ST_READ_WAIT: begin
            rd_en = 1'b1;
            if (cnt == 3'd0) state_nx = ST_RESP;
            else             cnt_nx   = cnt - 3'd1;
         end
         ST_RESP: begin
            resp     = 1'b1;
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         cnt           <= 3'd0;
         mem_out       <= '0;
         mem_out_valid <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         mem_out_valid <= resp;
         if (resp) mem_out <= rd_data;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (f_pop) begin
         cur_idx  <= head_idx;
         cur_data <= head_data;
      end
      if (ram_we) ram[cur_idx] <= cur_data;
      if (rd_en)  rd_data <= ram[cur_idx];
   end

endmodule

// File: tb/tb_hybrid_cache_memresp.sv
// Scoreboard bench for hybrid_cache_memresp with directed vectors.
module tb_hybrid_cache_memresp;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_in = '0;
   logic        mem_wrreq = 1'b0;
   logic        mem_rdreq = 1'b0;
   logic [31:0] mem_out;
   logic        mem_out_valid;
   logic        mem_pause;
   logic        mem_busy;
   logic        err_overflow;
   logic        err_proto;

   typedef struct {
      logic [31:0] data;
      int          icyc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   resp_cnt = 0;
   int   pause_seen = 0;

   hybrid_cache_memresp dut (
      .clk           (clk),
      .reset         (reset),
      .mem_addr      (mem_addr),
      .mem_in        (mem_in),
      .mem_wrreq     (mem_wrreq),
      .mem_rdreq     (mem_rdreq),
      .mem_out       (mem_out),
      .mem_out_valid (mem_out_valid),
      .mem_pause     (mem_pause),
      .mem_busy      (mem_busy),
      .err_overflow  (err_overflow),
      .err_proto     (err_proto)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_pause) pause_seen++;
         if (!reset && mem_out_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got data %h expected none",
                        mem_out);
            end else begin
               e = sb.pop_front();
               check("rd_data", mem_out, e.data);
               if (e.lat >= 0)
                  check("rd_latency", 32'(cyc - e.icyc), 32'(e.lat));
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Honors mem_pause before presenting a request for one edge.
   task automatic issue(input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      while (mem_pause && n < 50) begin
         idle(1);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL pause_timeout: got pause stuck expected release");
      end
      mem_wrreq = wr;
      mem_rdreq = rd;
      mem_addr  = a;
      mem_in    = d;
      idle(1);
      mem_wrreq = 1'b0;
      mem_rdreq = 1'b0;
   endtask

   task automatic read(input logic [31:0] a, input logic [31:0] d,
                       input int lat);
      exp_t e;
      issue(1'b0, 1'b1, a, '0);
      e.data = d;
      e.icyc = cyc;
      e.lat  = lat;
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || mem_busy) && n < 300) begin
         idle(1);
         n++;
      end
      idle(2);
      checks++;
      if (sb.size() != 0 || mem_busy) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      check("rst_mem_out", mem_out, 32'h0);
      check("rst_valid", 32'(mem_out_valid), 32'h0);
      check("rst_pause", 32'(mem_pause), 32'h0);
      check("rst_busy", 32'(mem_busy), 32'h0);
      check("rst_ovf", 32'(err_overflow), 32'h0);
      check("rst_proto", 32'(err_proto), 32'h0);
      idle(1);
   endtask

   initial begin
      int   base;
      exp_t e;
      logic [31:0] t4_idx [7];
      t4_idx = '{0, 1, 2, 3, 4, 5, 9};

      fork
         monitor();
      join_none

      // reset values
      idle(3);
      reset = 1'b0;
      check_reset_state();

      // single write then read, latency 4
      issue(1'b1, 1'b0, 32'h8000_0000, 32'h0fff_0001);
      idle(4);
      read(32'h8000_0000, 32'h0fff_0001, 4);
      wait_drain();

      // burst of writes, then ordered reads
      base = pause_seen;
      for (int i = 0; i < 16; i++)
         issue(1'b1, 1'b0, 32'h8000_0000 + 32'(4 * i), 32'h0fff_0001 + 32'(i));
      for (int i = 0; i < 4; i++)
         read(32'h8000_0010 + 32'(4 * i), 32'h0fff_0005 + 32'(i), -1);
      wait_drain();
      check("burst_pause_seen", 32'(pause_seen > base), 32'h1);
      check("burst_no_ovf", 32'(err_overflow), 32'h0);

      // address aliasing
      issue(1'b1, 1'b0, 32'h1234_5600, 32'hdead_beef);
      read(32'h0000_0600, 32'hdead_beef, -1);
      wait_drain();

      // sustained reads ignoring pause: r6..r8 are dropped
      for (int k = 0; k < 7; k++) begin
         e.data = 32'h0fff_0001 + t4_idx[k];
         e.icyc = 0;
         e.lat  = -1;
         sb.push_back(e);
      end
      base = resp_cnt;
      mem_rdreq = 1'b1;
      for (int i = 0; i < 10; i++) begin
         mem_addr = 32'h8000_0000 + 32'(4 * i);
         idle(1);
      end
      mem_rdreq = 1'b0;
      wait_drain();
      check("flood_ovf", 32'(err_overflow), 32'h1);
      check("flood_resp_cnt", 32'(resp_cnt - base), 32'd7);

      // simultaneous write and read request
      base = resp_cnt;
      issue(1'b1, 1'b1, 32'h8000_0038, 32'hffff_ffff);
      wait_drain();
      check("proto_flag", 32'(err_proto), 32'h1);
      check("proto_no_valid", 32'(resp_cnt - base), 32'd0);
      read(32'h8000_0038, 32'hffff_ffff, -1);
      wait_drain();

      // reset while a read is in READ_WAIT
      base = resp_cnt;
      issue(1'b0, 1'b1, 32'h8000_0004, '0);
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      check_reset_state();
      idle(8);
      check("rst_no_valid", 32'(resp_cnt - base), 32'd0);
      read(32'h8000_0004, 32'h0fff_0002, 4);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
